// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the single-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_e;
  typedef enum logic {GRANT_I, GRANT_D} grant_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-side, D-side and memory-side signals of the arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  localparam int MASK_W = DATA_W / 8;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [DATA_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [MASK_W-1:0] d_wmask;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic              d_resp;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [MASK_W-1:0] mem_wmask;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;
  logic              proto_err;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_wmask, d_address, d_wdata, mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_wmask, mem_address,
           mem_wdata, proto_err
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_wmask, d_address, d_wdata, mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_wmask, mem_address,
           mem_wdata, proto_err
  );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin chooser; on contention the side that did not win last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output grant_e grant
);
  assign grant = (req_i && req_d) ? ((last_grant == GRANT_D) ? GRANT_I : GRANT_D)
                                  : (req_i ? GRANT_I : GRANT_D);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an I-fetch reader and a D-side reader/writer,
// latching the winner's operands at grant so the memory sees them stable for the whole access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit D_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d, grant;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              proto_err_q, proto_err_d;
  logic              d_req, gi, start, done, i_resp, d_resp;
  assign d_req = bus.d_read | bus.d_write;
  rr_pick2 u_pick (
    .req_i     (bus.i_read),
    .req_d     (d_req),
    .last_grant(last_grant_q),
    .grant     (grant)
  );
  assign gi    = (grant == GRANT_I);
  assign start = (state_q == IDLE) && (bus.i_read || d_req);
  assign done  = (state_q != IDLE) && bus.mem_resp;
  // a D grant with both read and write high is performed as a write
  always_comb begin
    state_d       = start ? (gi ? SERVE_I : SERVE_D) : (done ? IDLE : state_q);
    last_grant_d  = start ? grant : last_grant_q;
    mem_read_d    = start ? (gi | (bus.d_read & ~bus.d_write)) : (mem_read_q & ~done);
    mem_write_d   = start ? (~gi & bus.d_write) : (mem_write_q & ~done);
    mem_wmask_d   = start ? (gi ? '0 : bus.d_wmask) : mem_wmask_q;
    mem_address_d = start ? (gi ? bus.i_address : bus.d_address) : mem_address_q;
    mem_wdata_d   = start ? (gi ? '0 : bus.d_wdata) : mem_wdata_q;
    proto_err_d   = proto_err_q | (start & ~gi & bus.d_read & bus.d_write);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= D_FIRST ? GRANT_I : GRANT_D;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      proto_err_q   <= proto_err_d;
    end
  end
  assign i_resp          = (state_q == SERVE_I) && bus.mem_resp;
  assign d_resp          = (state_q == SERVE_D) && bus.mem_resp;
  assign bus.i_resp      = i_resp;
  assign bus.d_resp      = d_resp;
  assign bus.i_rdata     = i_resp ? bus.mem_rdata : '0;
  assign bus.d_rdata     = d_resp ? bus.mem_rdata : '0;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.proto_err   = proto_err_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit memory between the instruction-fetch requester (I-side, read-only) and the data requester (D-side, read/write with byte mask).
- Sits between the mp3 core and the physical memory when the dual-port model is replaced by a single port.
- Round-robin arbitration on contention.
- Registers the address, data, mask and operation at grant, so the memory sees stable signals for the whole transaction.

Parameters:
- ADDR_W, 16, address width for all ports.
- DATA_W, 16, data width; must be a multiple of 8.
- MASK_W, DATA_W/8, byte-mask width; derived, not overridden.
- D_FIRST, 1, winner of the first contention after reset (1 = D-side, 0 = I-side).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_read  in  1  I-side read request; level, held until i_resp.
- i_address  in  ADDR_W  I-side address.
- i_resp  out  1  I-side completion, one-cycle pulse.
- i_rdata  out  DATA_W  I-side read data; valid only while i_resp=1.
- d_read  in  1  D-side read request.
- d_write  in  1  D-side write request.
- d_wmask  in  MASK_W  D-side byte-write mask.
- d_address  in  ADDR_W  D-side address.
- d_wdata  in  DATA_W  D-side write data.
- d_resp  out  1  D-side completion pulse.
- d_rdata  out  DATA_W  D-side read data; valid only while d_resp=1.
- mem_read  out  1  memory read strobe; registered.
- mem_write  out  1  memory write strobe; registered.
- mem_wmask  out  MASK_W  registered byte mask.
- mem_address  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_resp  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.
- proto_err  out  1  sticky flag: d_read and d_write were both high at a D-side grant.

Behaviour:
- FSM states:
  - IDLE: no transaction in flight.
  - SERVE_I / SERVE_D: transaction in flight for that side.
- Reset (asynchronous):
  - State goes to IDLE immediately.
  - All mem_* outputs, i_resp, d_resp, i_rdata, d_rdata and proto_err go to 0.
  - last_grant is set to the value that makes the D_FIRST side win the next contention.
  - A reset mid-transaction abandons the transaction. No resp is issued; the memory sees its strobe drop.
- IDLE, at each edge:
  - Only i_read high -> SERVE_I.
  - d_read or d_write high (I-side idle) -> SERVE_D.
  - Both sides requesting -> grant the side NOT equal to last_grant.
  - Nothing requesting -> stay in IDLE.
- At the grant edge:
  - The granted side's address, wdata, wmask and operation are registered onto mem_*.
  - last_grant is updated.
  - For an I-side grant: mem_read=1, mem_wmask=0, mem_wdata=0.
- D-side both-high case: if d_read and d_write are both high at grant, the operation is a write and proto_err is set. proto_err is cleared only by rst.
- SERVE_x with mem_resp=0:
  - Hold all mem_* outputs stable.
  - Requester input changes are ignored.
- SERVE_x with mem_resp=1, in the same cycle (combinational):
  - x_resp=1 and x_rdata=mem_rdata; x_rdata is 0 otherwise.
  - At the next edge: mem_read and mem_write go to 0, and the state returns to IDLE.
- Issue gap: there is always at least one IDLE cycle between transactions. The requester is expected to drop its request after seeing resp. The next grant is taken from the request levels sampled in IDLE.
- Latency:
  - Request seen in IDLE at edge N -> memory strobe from cycle N+1.
  - Completion visible to the requester in the same cycle as mem_resp.
  - The arbiter therefore adds 1 cycle per access, plus 1 IDLE cycle after each access.
- Abandoned request: if a requester drops its request mid-transaction, the transaction still completes and resp is still pulsed.
- mem_resp while in IDLE: ignored; no resp is generated.
- Starvation bound: with both sides requesting continuously, grants strictly alternate.
- Widths: no arithmetic. All data and mask paths are exact-width pass-through or registers.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e {IDLE, SERVE_I, SERVE_D}.
  - grant_e {GRANT_I, GRANT_D}.
  - Default width constants.
- One natural sub-module, rr_pick2: 2-way round-robin chooser; inputs req_i, req_d, last_grant; output grant.
- FSM, operand registers and resp muxing stay in mem_port_arbiter.

Test Plan:
- Lone I read: i_read=1, i_address=16'h0040; memory returns 16'hBEEF after 3 cycles -> mem_read rises 1 cycle after request, mem_address=16'h0040, i_resp pulses once with i_rdata=16'hBEEF, d_resp stays 0.
- Lone D write: d_write=1, d_address=16'h1002, d_wdata=16'h00A5, d_wmask=2'b01 -> mem_write=1 with identical registered values, d_resp pulses once, mem_read stays 0.
- Contention from reset: with D_FIRST=1, i_read and d_read both rise in the same cycle -> D served first, then I after one IDLE cycle. With both held high, grant order is D,I,D,I.
- Input change mid-transaction: change d_address from 16'h2000 to 16'h3000 while in SERVE_D -> mem_address stays 16'h2000 until the transaction ends.
- Async reset mid-transaction: assert rst while in SERVE_I -> mem_read=0 and i_resp=0 immediately, without waiting for clk. After release, a new i_read completes normally.
- Protocol error: d_read=d_write=1 -> performed as a write (mem_write=1, mem_read=0), proto_err=1 and stays set until rst.
